voice_allocator: RTL and testbench

- Polyphonic note scheduler placed upstream of the per-voice note2dds_1st_gen / DDS / waveform chains.
- Accepts a serial stream of note-on and note-off events over a valid/ready handshake and assigns each event to one of VOICES voice slots.
- Drives each voice's NOTE input and gate.
- Pulses a per-voice retrigger so downstream logic can reset that voice's phase and envelope.

---
 rtl/voice_allocator.sv | 153 +++++++++++++++
 tb/tb_voice_allocator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial note-on/off events are scanned against VOICES slots and committed.
// Optional macro VOICE_STEAL_EN: a note-on with no matching or free voice steals the oldest gated voice.
module voice_allocator #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ev_valid,
    output logic                ev_ready,
    input  logic                ev_on,
    input  logic [7:0]          ev_note,
    output logic [8*VOICES-1:0] voice_note,
    output logic [VOICES-1:0]   voice_gate,
    output logic [VOICES-1:0]   voice_retrig,
    output logic                drop
);
    // state  | meaning
    // IDLE   | ready for an event
    // SCAN   | one voice per cycle, building match/free/oldest trackers
    // COMMIT | apply the event to the chosen voice, pulse retrig or drop
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] target;
    logic             match_found;
    logic             free_found;
    logic             has_target;
    logic             ev_on_q;
    logic [7:0]       ev_note_q;
    logic [AGE_W-1:0] age [VOICES];
    logic [7:0]       scan_note;
    logic             scan_gate;
`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;
    logic             old_found;
    logic [AGE_W-1:0] scan_age;

    assign scan_age = age[idx];
`endif

    assign ev_ready  = (state == IDLE) && !reset;
    assign scan_note = voice_note[8*idx +: 8];
    assign scan_gate = voice_gate[idx];

    always_comb begin
        has_target = 1'b0;
        target     = '0;
        if (match_found) begin
            has_target = 1'b1;
            target     = match_idx;
        end else if (free_found) begin
            has_target = 1'b1;
            target     = free_idx;
        end
`ifdef VOICE_STEAL_EN
        else if (old_found) begin
            has_target = 1'b1;
            target     = old_idx;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            match_idx    <= '0;
            free_idx     <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            ev_on_q      <= 1'b0;
            ev_note_q    <= '0;
            voice_note   <= '0;
            voice_gate   <= '0;
            voice_retrig <= '0;
            drop         <= 1'b0;
            for (int i = 0; i < VOICES; i++) age[i] <= '0;
`ifdef VOICE_STEAL_EN
            old_idx      <= '0;
            old_age      <= '0;
            old_found    <= 1'b0;
`endif
        end else begin
            voice_retrig <= '0;
            drop         <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_valid) begin
                        ev_on_q     <= ev_on;
                        ev_note_q   <= ev_note;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
`ifdef VOICE_STEAL_EN
                        old_found   <= 1'b0;
`endif
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_gate && (scan_note == ev_note_q) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!scan_gate && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
`ifdef VOICE_STEAL_EN
                    // strict compare keeps the lowest index on equal ages
                    if (scan_gate && (!old_found || (scan_age > old_age))) begin
                        old_found <= 1'b1;
                        old_idx   <= idx;
                        old_age   <= scan_age;
                    end
`endif
                    if (idx == IDX_W'(VOICES - 1)) state <= COMMIT;
                    else idx <= idx + 1'b1;
                end
                COMMIT: begin
                    state <= IDLE;
                    if (ev_note_q[7]) begin
                        drop <= 1'b1;
                    end else if (ev_on_q) begin
                        if (has_target) begin
                            for (int i = 0; i < VOICES; i++)
                                if (voice_gate[i] && (age[i] != '1)) age[i] <= age[i] + 1'b1;
                            // later assignment overrides the loop for the target itself
                            age[target]               <= '0;
                            voice_note[8*target +: 8] <= ev_note_q;
                            voice_gate[target]        <= 1'b1;
                            voice_retrig[target]      <= 1'b1;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (match_found) begin
                        voice_gate[match_idx] <= 1'b0;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: constant vector table, hand corner cases, random events vs model.
module tb_voice_allocator;
    localparam int VOICES  = 4;
    localparam int AGE_W   = 4;
    localparam int AGE_MAX = (1 << AGE_W) - 1;

    logic                clk;
    logic                reset;
    logic                ev_valid;
    logic                ev_ready;
    logic                ev_on;
    logic [7:0]          ev_note;
    logic [8*VOICES-1:0] voice_note;
    logic [VOICES-1:0]   voice_gate;
    logic [VOICES-1:0]   voice_retrig;
    logic                drop;

    int checks = 0;
    int errors = 0;

    voice_allocator #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .voice_note(voice_note),
        .voice_gate(voice_gate), .voice_retrig(voice_retrig), .drop(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        on;
        logic [7:0]  note;
        logic [31:0] notes;
        logic [3:0]  gate;
        logic [3:0]  ret;
        logic        drp;
    } vec_t;

    vec_t tbl [12];

    // reference model: plain per-voice arrays
    logic [7:0] m_note [VOICES];
    logic [3:0] m_gate;
    int         m_age  [VOICES];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_gate = '0;
        for (int i = 0; i < VOICES; i++) begin
            m_note[i] = '0;
            m_age[i]  = 0;
        end
    endtask

    function automatic logic [31:0] model_notes();
        logic [31:0] v;
        for (int i = 0; i < VOICES; i++) v[8*i +: 8] = m_note[i];
        return v;
    endfunction

    task automatic model_apply(input logic on, input logic [7:0] note,
                               output logic [3:0] ret, output logic drp);
        int m, f, t;
        ret = '0; drp = 1'b0; m = -1; f = -1;
        for (int i = 0; i < VOICES; i++) begin
            if (m_gate[i] && m_note[i] == note && m < 0) m = i;
            if (!m_gate[i] && f < 0) f = i;
        end
        if (note >= 8'd128) begin
            drp = 1'b1;
        end else if (!on) begin
            if (m >= 0) m_gate[m] = 1'b0;
            else drp = 1'b1;
        end else begin
            t = (m >= 0) ? m : f;
`ifdef VOICE_STEAL_EN
            if (t < 0) begin
                int best_age;
                best_age = -1;
                for (int i = 0; i < VOICES; i++)
                    if (m_gate[i] && m_age[i] > best_age) begin
                        best_age = m_age[i];
                        t = i;
                    end
            end
`endif
            if (t < 0) begin
                drp = 1'b1;
            end else begin
                for (int i = 0; i < VOICES; i++)
                    if (i != t && m_gate[i]) m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
                m_age[t]  = 0;
                m_note[t] = note;
                m_gate[t] = 1'b1;
                ret[t]    = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {ev_ready, voice_gate, voice_retrig, drop, voice_note},
            {1'b0, 4'b0, 4'b0, 1'b0, 32'h0});
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic send_event(input logic on, input logic [7:0] note, input logic [31:0] exp_notes,
                              input logic [3:0] exp_gate, input logic [3:0] exp_ret,
                              input logic exp_drop, input string tag);
        int w;
        logic [31:0] pre_notes;
        logic [3:0]  pre_gate;
        @(negedge clk);
        w = 0;
        while (!ev_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ev_ready) begin
            chk({tag, " ready_timeout"}, ev_ready, 1);
            return;
        end
        pre_notes = voice_note;
        pre_gate  = voice_gate;
        ev_valid = 1'b1; ev_on = on; ev_note = note;
        @(posedge clk); #1;
        for (int k = 0; k <= VOICES; k++) begin
            chk($sformatf("%s busy%0d", tag, k),
                {voice_gate, voice_note, voice_retrig, drop, ev_ready},
                {pre_gate, pre_notes, 4'b0, 1'b0, 1'b0});
            // toggling the handshake inputs while busy must not matter
            ev_valid = (k < VOICES - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            ev_on    = 1'($urandom_range(0, 1));
            ev_note  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        chk({tag, " notes"}, voice_note, exp_notes);
        chk({tag, " gate"}, voice_gate, exp_gate);
        chk({tag, " retrig"}, voice_retrig, exp_ret);
        chk({tag, " drop"}, drop, exp_drop);
        chk({tag, " ready"}, ev_ready, 1);
        @(posedge clk); #1;
        chk({tag, " pulse_end"}, {voice_retrig, drop}, 5'b0);
    endtask

    initial begin
        logic [3:0] r;
        logic       d;
        logic       on;
        logic [7:0] nt;
        reset = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0;

        tbl[0]  = '{1'b1, 8'd60,  {8'd0,  8'd0,  8'd0,  8'd60}, 4'b0001, 4'b0001, 1'b0};
        tbl[1]  = '{1'b1, 8'd64,  {8'd0,  8'd0,  8'd64, 8'd60}, 4'b0011, 4'b0010, 1'b0};
        tbl[2]  = '{1'b1, 8'd67,  {8'd0,  8'd67, 8'd64, 8'd60}, 4'b0111, 4'b0100, 1'b0};
        tbl[3]  = '{1'b1, 8'd72,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1111, 4'b1000, 1'b0};
        tbl[4]  = '{1'b0, 8'd64,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1101, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 8'd50,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1101, 4'b0000, 1'b1};
        tbl[6]  = '{1'b1, 8'd200, {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1101, 4'b0000, 1'b1};
        tbl[7]  = '{1'b1, 8'd64,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1111, 4'b0010, 1'b0};
`ifdef VOICE_STEAL_EN
        tbl[8]  = '{1'b1, 8'd76,  {8'd72, 8'd67, 8'd64, 8'd76}, 4'b1111, 4'b0001, 1'b0};
        tbl[9]  = '{1'b1, 8'd60,  {8'd72, 8'd60, 8'd64, 8'd76}, 4'b1111, 4'b0100, 1'b0};
        tbl[10] = '{1'b0, 8'd60,  {8'd72, 8'd60, 8'd64, 8'd76}, 4'b1011, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 8'd60,  {8'd72, 8'd60, 8'd64, 8'd76}, 4'b1011, 4'b0000, 1'b1};
`else
        tbl[8]  = '{1'b1, 8'd76,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1111, 4'b0000, 1'b1};
        tbl[9]  = '{1'b1, 8'd60,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1111, 4'b0001, 1'b0};
        tbl[10] = '{1'b0, 8'd60,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1110, 4'b0000, 1'b0};
        tbl[11] = '{1'b0, 8'd60,  {8'd72, 8'd67, 8'd64, 8'd60}, 4'b1110, 4'b0000, 1'b1};
`endif

        do_reset();
        for (int i = 0; i < 12; i++)
            send_event(tbl[i].on, tbl[i].note, tbl[i].notes, tbl[i].gate, tbl[i].ret,
                       tbl[i].drp, $sformatf("tbl%0d", i));

        // drops with nothing sounding, then a repeated note-on retriggering the same voice
        do_reset();
        send_event(1'b0, 8'd50,  32'h0, 4'b0000, 4'b0000, 1'b1, "off_empty");
        send_event(1'b1, 8'd200, 32'h0, 4'b0000, 4'b0000, 1'b1, "on_200");
        send_event(1'b1, 8'd60,  {24'h0, 8'd60}, 4'b0001, 4'b0001, 1'b0, "on60_a");
        send_event(1'b1, 8'd60,  {24'h0, 8'd60}, 4'b0001, 4'b0001, 1'b0, "on60_b");

        // reset in the middle of a scan discards the pending event
        @(negedge clk);
        chk("pre_scan_ready", ev_ready, 1);
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 8'd62;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_in_reset", ev_ready, 0);
        @(posedge clk); #1;
        chk("midscan_reset", {voice_gate, voice_retrig, drop, voice_note}, 41'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", ev_ready, 1);
        repeat (VOICES + 2) @(posedge clk);
        #1;
        chk("no_late_commit", {voice_gate, voice_retrig, drop}, 9'h0);

        // random events against the model
        do_reset();
        for (int n = 0; n < 150; n++) begin
            on = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) nt = 8'(128 + $urandom_range(0, 127));
            else nt = 8'(60 + $urandom_range(0, 7));
            model_apply(on, nt, r, d);
            send_event(on, nt, model_notes(), m_gate, r, d, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
